// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage constants: default widths, reset PC, PC increment and the NOP
// encoding agreed with the decode/execute side.
package instr_fetch_unit_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam int          DATA_W_DEF   = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          PC_STEP      = 4;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   // Width of a counter that must hold every value from 0 up to depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Synchronous FIFO holding {pc, instr} pairs returned by instruction memory.
// Supports flush, and push with pop in the same cycle even when full.
module instr_fetch_unit_fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop    = pop && (count != '0);
   // A full buffer still accepts a write when the head leaves in the same cycle.
   assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit, buffers
// responses with their PC and hands one instruction per cycle to decode.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                BUF_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              id_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              err_spurious
);

   localparam int                CNT_W = cnt_width(BUF_DEPTH);
   localparam int                ENT_W = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [ADDR_W-1:0] redirect_aligned;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  out_after_resp;
   logic [CNT_W-1:0]  buf_count;
   logic [CNT_W:0]    credit_used;
   logic [ENT_W-1:0]  head;
   logic              buf_nonempty;
   logic              pop;
   logic              push;
   logic              gnt_fire;
   logic              resp_fire;

   assign buf_nonempty     = (buf_count != '0);
   assign if_valid         = buf_nonempty && !redirect_valid;
   assign pop              = if_valid && id_ready;
   assign if_instr         = buf_nonempty ? head[DATA_W-1:0]     : '0;
   assign if_pc            = buf_nonempty ? head[ENT_W-1:DATA_W] : '0;
   assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

   // The slot freed by this cycle's pop is lent to a new request, which is what lets a
   // two-entry buffer keep up with one instruction per cycle.
   assign credit_used = {1'b0, buf_count} + {1'b0, outstanding} - (CNT_W+1)'(pop);
   assign imem_req    = !reset && !redirect_valid && (credit_used < (CNT_W+1)'(BUF_DEPTH));
   assign imem_addr   = pc;
   assign gnt_fire    = imem_req && imem_gnt;

   assign resp_fire      = imem_rvalid && (outstanding != '0);
   assign out_after_resp = outstanding - CNT_W'(resp_fire);
   assign push           = resp_fire && !redirect_valid && (drop_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= RESET_PC;
         resp_pc      <= RESET_PC;
         outstanding  <= '0;
         drop_cnt     <= '0;
         err_spurious <= 1'b0;
      end else begin
         outstanding <= out_after_resp + CNT_W'(gnt_fire);
         if (imem_rvalid && (outstanding == '0)) err_spurious <= 1'b1;
         // Everything still in flight after a redirect belongs to the old path.
         if (redirect_valid) begin
            pc       <= redirect_aligned;
            resp_pc  <= redirect_aligned;
            drop_cnt <= out_after_resp;
         end else begin
            if (gnt_fire) pc <= pc + STEP;
            if (push)     resp_pc <= resp_pc + STEP;
            if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
         end
      end
   end

   instr_fetch_unit_fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENT_W)
   ) u_fetch_buffer (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({resp_pc, imem_rdata}),
      .pop       (pop),
      .head_data (head),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomised checks of instr_fetch_unit against a behavioural memory and an
// in-order expected-PC stream.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        err_spurious;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .err_spurious   (err_spurious)
   );

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } pend_t;

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_v;
      logic [31:0] exp_pc;
   } vec_t;

   pend_t       pend[$];
   vec_t        tbl[21];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          npops = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          gnt_rand = 0;
   bit          rdy_rand = 0;
   logic        gnt_fixed = 1'b1;
   logic [31:0] exp_next = 32'h0;

   function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                               input logic req, input logic [31:0] addr,
                               input logic v, input logic [31:0] pc);
      vec_t t;
      t.rdy = rdy; t.redir = redir; t.rpc = rpc;
      t.exp_req = req; t.exp_addr = addr; t.exp_v = v; t.exp_pc = pc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at the negedge: score pops, record grants, then step memory past the posedge.
   task automatic fin_cycle();
      if (if_valid && id_ready) begin
         npops++;
         chk("pop pc", if_pc, exp_next);
         chk("pop instr", if_instr, exp_next ^ 32'hA5A5_0000);
         exp_next = exp_next + 32'd4;
      end
      if (redirect_valid) exp_next = redirect_pc & 32'hFFFF_FFFC;
      if (imem_req && imem_gnt)
         pend.push_back('{addr: imem_addr, ready: cyc + int'($urandom_range(lat_max, lat_min))});
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].ready <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend[0].addr ^ 32'hA5A5_0000;
         void'(pend.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
      imem_gnt = gnt_rand ? ($urandom_range(3, 0) != 0) : gnt_fixed;
      if (rdy_rand) id_ready = ($urandom_range(1, 0) == 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " imem_req"}, {31'h0, imem_req}, 32'h0);
      chk({tag, " imem_addr"}, imem_addr, 32'h0);
      chk({tag, " if_valid"}, {31'h0, if_valid}, 32'h0);
      chk({tag, " if_instr"}, if_instr, 32'h0);
      chk({tag, " if_pc"}, if_pc, 32'h0);
   endtask

   task automatic do_reset(input string tag);
      rst            = 1'b1;
      pend.delete();
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs(tag);
      chk({tag, " err_spurious"}, {31'h0, err_spurious}, 32'h0);
      imem_gnt = gnt_fixed;
      exp_next = 32'h0;
      rst      = 1'b0;
   endtask

   task automatic wait_pops(input int target, input int budget, input string name);
      int start;
      int k;
      start = npops;
      k     = 0;
      while ((npops - start) < target && k < budget) begin
         @(negedge clk);
         fin_cycle();
         k++;
      end
      chk(name, 32'(npops - start), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

      //          rdy redir rpc         req addr          v  pc
      tbl[0]  = mk(0, 0, 32'h0,   1, 32'h000, 0, 32'h000);
      tbl[1]  = mk(0, 0, 32'h0,   1, 32'h004, 0, 32'h000);
      tbl[2]  = mk(0, 0, 32'h0,   0, 32'h008, 1, 32'h000);
      tbl[3]  = mk(0, 0, 32'h0,   0, 32'h008, 1, 32'h000);
      tbl[4]  = mk(0, 0, 32'h0,   0, 32'h008, 1, 32'h000);
      tbl[5]  = mk(1, 0, 32'h0,   1, 32'h008, 1, 32'h000);
      tbl[6]  = mk(1, 0, 32'h0,   1, 32'h00C, 1, 32'h004);
      tbl[7]  = mk(1, 0, 32'h0,   1, 32'h010, 1, 32'h008);
      tbl[8]  = mk(0, 0, 32'h0,   0, 32'h014, 1, 32'h00C);
      tbl[9]  = mk(0, 0, 32'h0,   0, 32'h014, 1, 32'h00C);
      tbl[10] = mk(1, 1, 32'h100, 0, 32'h014, 0, 32'h000);
      tbl[11] = mk(1, 0, 32'h0,   1, 32'h100, 0, 32'h000);
      tbl[12] = mk(1, 0, 32'h0,   1, 32'h104, 0, 32'h000);
      tbl[13] = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
      tbl[14] = mk(1, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
      tbl[15] = mk(1, 1, 32'h2F1, 0, 32'h110, 0, 32'h000);
      tbl[16] = mk(1, 1, 32'h103, 0, 32'h2F0, 0, 32'h000);
      tbl[17] = mk(1, 0, 32'h0,   1, 32'h100, 0, 32'h000);
      tbl[18] = mk(1, 0, 32'h0,   1, 32'h104, 0, 32'h000);
      tbl[19] = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
      tbl[20] = mk(1, 0, 32'h0,   1, 32'h10C, 1, 32'h104);

      // Zero-wait memory: startup, stall with full buffer, redirects (full buffer,
      // coincident response and pop, back-to-back with unaligned target).
      gnt_fixed = 1'b1; lat_min = 1; lat_max = 1;
      do_reset("reset");
      for (int i = 0; i < 21; i++) begin
         id_ready       = tbl[i].rdy;
         redirect_valid = tbl[i].redir;
         redirect_pc    = tbl[i].rpc;
         @(negedge clk);
         chk($sformatf("row%0d imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].exp_req});
         chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("row%0d if_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].exp_v});
         if (tbl[i].exp_v) begin
            chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].exp_pc);
            chk($sformatf("row%0d if_instr", i), if_instr, tbl[i].exp_pc ^ 32'hA5A5_0000);
         end
         fin_cycle();
      end
      redirect_valid = 1'b0;
      chk("no spurious after table", {31'h0, err_spurious}, 32'h0);

      // Redirect with two requests in flight: both responses must be dropped.
      do_reset("reset drop2");
      lat_min = 3; lat_max = 3; id_ready = 1'b1;
      @(negedge clk); chk("drop2 d0 req", {31'h0, imem_req}, 32'h1); fin_cycle();
      @(negedge clk); chk("drop2 d1 req", {31'h0, imem_req}, 32'h1); fin_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("drop2 redirect req", {31'h0, imem_req}, 32'h0);
      chk("drop2 redirect if_valid", {31'h0, if_valid}, 32'h0);
      fin_cycle();
      redirect_valid = 1'b0;
      wait_pops(3, 40, "drop2 stream count");

      // Redirect in the same cycle a response returns, one more still in flight.
      do_reset("reset drop1");
      lat_min = 2; lat_max = 2; id_ready = 1'b0;
      @(negedge clk); fin_cycle();
      @(negedge clk); fin_cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      @(negedge clk);
      chk("drop1 rvalid in redirect", {31'h0, imem_rvalid}, 32'h1);
      fin_cycle();
      redirect_valid = 1'b0; id_ready = 1'b1;
      wait_pops(3, 40, "drop1 stream count");
      chk("no spurious after drops", {31'h0, err_spurious}, 32'h0);

      // Grant withheld: address must hold, then stream resumes from 0.
      gnt_fixed = 1'b0;
      do_reset("reset nognt");
      lat_min = 1; lat_max = 1; id_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("nognt%0d req", i), {31'h0, imem_req}, 32'h1);
         chk($sformatf("nognt%0d addr", i), imem_addr, 32'h0);
         fin_cycle();
      end
      gnt_fixed = 1'b1; imem_gnt = 1'b1;
      wait_pops(4, 20, "after gnt stream count");

      // Random grant, latency and decode back-pressure against the in-order stream.
      gnt_rand = 1; rdy_rand = 1; lat_min = 1; lat_max = 4;
      wait_pops(150, 3000, "random stream count");

      // Asynchronous reset mid-stream, then a stray response.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outs("midrst async");
      gnt_rand = 0; rdy_rand = 0; lat_min = 1; lat_max = 1;
      pend.delete();
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      @(posedge clk);
      #1;
      chk_reset_outs("midrst held");
      chk("midrst err_spurious", {31'h0, err_spurious}, 32'h0);
      id_ready = 1'b1; gnt_fixed = 1'b0; imem_gnt = 1'b0; exp_next = 32'h0;
      rst = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stray before edge", {31'h0, err_spurious}, 32'h0);
      gnt_fixed = 1'b1;
      fin_cycle();
      @(negedge clk);
      chk("stray sets err", {31'h0, err_spurious}, 32'h1);
      chk("restart addr", imem_addr, 32'h0);
      chk("stray not buffered", {31'h0, if_valid}, 32'h0);
      fin_cycle();
      wait_pops(3, 20, "restart stream count");
      chk("err sticky", {31'h0, err_spurious}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
